// File: rtl/uart_tx_engine.sv
// UART transmit engine: TX FIFO, per-bit baud down-counter and frame FSM.
// Parity generation and the PARITY state exist only when UART_TX_PARITY_EN is defined.
module uart_tx_engine #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tx_en,
   input  logic                        wr_en,
   input  logic [DATA_W-1:0]           wr_data,
   input  logic [7:0]                  lcr,
   input  logic [DIV_W-1:0]            div,
   output logic                        tx,
   output logic                        busy,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        ovf,
   output logic                        tx_done
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t            state, state_d;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [DATA_W-1:0] fifo_head;
   logic              wr_acc, pop;
   logic [DIV_W-1:0]  div_eff, div_q, cnt;
   logic [BW-1:0]     bit_idx;
   logic              stop_idx, stop2_q;
   logic [DATA_W-1:0] shreg;
   logic              bit_last, data_last, frame_end;
   logic              tx_d;
   logic              unused_lcr;

`ifdef UART_TX_PARITY_EN
   logic par_en_q, par_q, par_bit;
   assign par_bit    = lcr[5] ? ~lcr[4] : (lcr[4] ? ^fifo_head : ~(^fifo_head));
   assign unused_lcr = ^{lcr[7:6], lcr[1:0]};
`else
   assign unused_lcr = ^{lcr[7:3], lcr[1:0]};
`endif

   assign full      = (level == LW'(FIFO_DEPTH));
   assign empty     = (level == '0);
   assign wr_acc    = wr_en && !full;
   assign fifo_head = mem[rd_ptr];
   assign div_eff   = (div == '0) ? DIV_W'(1) : div;
   assign bit_last  = (cnt == '0);
   assign data_last = (bit_idx == BW'(DATA_W - 1));
   assign frame_end = (state == STOP) && bit_last && (stop_idx == stop2_q);
   // A pop both starts a frame from IDLE and chains the next frame off the final stop bit.
   assign pop       = tx_en && !empty && ((state == IDLE) || frame_end);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(wr_acc) - LW'(pop);
         if (wr_en && full) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (pop) begin
         shreg <= fifo_head;
         div_q <= div_eff;
`ifdef UART_TX_PARITY_EN
         par_q <= par_bit;
`endif
      end else if ((state == DATA) && bit_last) begin
         shreg <= shreg >> 1;
      end
   end

   // Bit timing and frame configuration are frozen at the pop so mid-frame lcr/div edits are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         stop2_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q <= 1'b0;
`endif
      end else if (pop) begin
         cnt      <= div_eff - DIV_W'(1);
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         stop2_q  <= lcr[2];
`ifdef UART_TX_PARITY_EN
         par_en_q <= lcr[3];
`endif
      end else if (state != IDLE) begin
         if (bit_last) begin
            cnt <= div_q - DIV_W'(1);
            if (state == DATA) bit_idx  <= bit_idx + BW'(1);
            if (state == STOP) stop_idx <= 1'b1;
         end else begin
            cnt <= cnt - DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:  if (pop) state_d = START;
         START: if (bit_last) state_d = DATA;
         DATA: begin
            if (bit_last && data_last) begin
`ifdef UART_TX_PARITY_EN
               state_d = par_en_q ? PARITY : STOP;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_last) state_d = STOP;
`endif
         STOP:  if (frame_end) state_d = pop ? START : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_d = 1'b1;
      case (state)
         START:  tx_d = 1'b0;
         DATA:   tx_d = shreg[0];
`ifdef UART_TX_PARITY_EN
         PARITY: tx_d = par_q;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   // Line, busy and done are registered together so all three describe the same bit on the wire.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx      <= 1'b1;
         busy    <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         tx      <= tx_d;
         busy    <= (state != IDLE);
         tx_done <= frame_end;
      end
   end
endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: table of single frames plus FIFO overflow,
// back-to-back two-stop frames and mid-frame reset sequences.
module tb_uart_tx_engine;
   logic        clk = 1'b0;
   logic        rst, tx_en, wr_en;
   logic [7:0]  wr_data, lcr;
   logic [15:0] div;
   logic        tx, busy, full, empty, ovf, tx_done;
   logic [2:0]  level;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  lcr;
      logic [15:0] div;
      logic [7:0]  data;
      logic [11:0] exp;   // line bits in send order, first bit at [11]
      int          nbits;
   } vec_t;

   vec_t vecs[$];

   uart_tx_engine #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
      .clk(clk), .rst(rst), .tx_en(tx_en), .wr_en(wr_en), .wr_data(wr_data),
      .lcr(lcr), .div(div), .tx(tx), .busy(busy), .full(full), .empty(empty),
      .level(level), .ovf(ovf), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic write_byte(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic rx_byte(output logic [7:0] d, output bit ok);
      int w;
      w  = 0;
      ok = 1'b1;
      d  = 8'h00;
      while (tx !== 1'b0 && w < 50) begin
         tick();
         w++;
      end
      if (tx !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         d[i] = tx;
      end
      tick();
      if (tx !== 1'b1) ok = 1'b0;
   endtask

   function automatic vec_t mk(input logic [7:0] l, input logic [15:0] d, input logic [7:0] dat,
                               input logic [11:0] e, input int n);
      vec_t r;
      r.lcr = l; r.div = d; r.data = dat; r.exp = e; r.nbits = n;
      return r;
   endfunction

   initial begin
      logic [7:0] rxd;
      bit         ok;
      int         dv, lows, dones;
      logic [7:0] q36 [4];
      logic [7:0] d37 [2];
      logic       exp37 [22];

      rst = 1'b1; tx_en = 1'b0; wr_en = 1'b0; wr_data = 8'h00; lcr = 8'h00; div = 16'd4;
      vecs.push_back(mk(8'h00, 16'd4, 8'hA5, 12'b010100101100, 10));
      vecs.push_back(mk(8'h00, 16'd1, 8'h3C, 12'b000111100100, 10));
      vecs.push_back(mk(8'h04, 16'd2, 8'h81, 12'b010000001110, 11));
      vecs.push_back(mk(8'h00, 16'd0, 8'h00, 12'b000000000100, 10));
`ifdef UART_TX_PARITY_EN
      vecs.push_back(mk(8'h18, 16'd3, 8'hA5, 12'b010100101010, 11));
      vecs.push_back(mk(8'h08, 16'd2, 8'hA5, 12'b010100101110, 11));
      vecs.push_back(mk(8'h28, 16'd2, 8'hA5, 12'b010100101110, 11));
      vecs.push_back(mk(8'h28, 16'd2, 8'h5A, 12'b001011010110, 11));
      vecs.push_back(mk(8'h1C, 16'd1, 8'h01, 12'b010000000111, 12));
`else
      vecs.push_back(mk(8'h18, 16'd3, 8'hA5, 12'b010100101100, 10));
      vecs.push_back(mk(8'h28, 16'd2, 8'h5A, 12'b001011010100, 10));
`endif

      // Reset state
      repeat (3) tick();
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_level", level, 0);
      check("rst_ovf", ovf, 0);
      check("rst_done", tx_done, 0);
      rst = 1'b0;
      tick();

      // Single frames; lcr/div are scrambled right after the pop to prove they are latched
      for (int v = 0; v < vecs.size(); v++) begin
         lcr   = vecs[v].lcr;
         div   = vecs[v].div;
         dv    = (vecs[v].div == 16'd0) ? 1 : int'(vecs[v].div);
         tx_en = 1'b1;
         write_byte(vecs[v].data);
         check($sformatf("v%0d_edgeN_tx", v), tx, 1);
         tick();
         lcr = 8'hFF;
         div = 16'd9;
         check($sformatf("v%0d_edgeN1_tx", v), tx, 1);
         for (int b = 0; b < vecs[v].nbits; b++) begin
            for (int c = 0; c < dv; c++) begin
               tick();
               check($sformatf("v%0d_b%0d_c%0d_tx", v, b, c), tx, vecs[v].exp[11-b]);
               check($sformatf("v%0d_b%0d_c%0d_done", v, b, c), tx_done,
                     (b == vecs[v].nbits - 1) && (c == dv - 1));
               check($sformatf("v%0d_b%0d_c%0d_busy", v, b, c), busy, 1);
            end
         end
         tick();
         check($sformatf("v%0d_end_tx", v), tx, 1);
         check($sformatf("v%0d_end_busy", v), busy, 0);
         check($sformatf("v%0d_end_done", v), tx_done, 0);
      end

      // FIFO overflow with tx disabled: fifth byte dropped
      tx_en = 1'b0; lcr = 8'h00; div = 16'd0;
      q36[0] = 8'h11; q36[1] = 8'h22; q36[2] = 8'h33; q36[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         write_byte(q36[i]);
         check($sformatf("ovf_level%0d", i), level, i + 1);
      end
      check("ovf_before", ovf, 0);
      check("full_at4", full, 1);
      write_byte(8'h55);
      check("ovf_level_after5", level, 4);
      check("ovf_full", full, 1);
      check("ovf_set", ovf, 1);
      check("ovf_tx_idle", tx, 1);
      tx_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rx_byte(rxd, ok);
         check($sformatf("ovf_rx%0d_ok", i), ok, 1);
         check($sformatf("ovf_rx%0d_data", i), rxd, q36[i]);
      end
      lows = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tx !== 1'b1) lows++;
      end
      check("ovf_no_fifth_frame", lows, 0);
      check("ovf_drained_level", level, 0);
      check("ovf_drained_empty", empty, 1);
      check("ovf_sticky", ovf, 1);

      // Two queued bytes, div=0, two stop bits: frames must abut
      tx_en = 1'b0; lcr = 8'h04; div = 16'd0;
      d37[0] = 8'h5A; d37[1] = 8'hC3;
      for (int f = 0; f < 2; f++) begin
         exp37[f*11] = 1'b0;
         for (int i = 0; i < 8; i++) exp37[f*11+1+i] = d37[f][i];
         exp37[f*11+9]  = 1'b1;
         exp37[f*11+10] = 1'b1;
      end
      write_byte(d37[0]);
      write_byte(d37[1]);
      check("b2b_level", level, 2);
      tx_en = 1'b1;
      tick();
      check("b2b_pre_tx", tx, 1);
      for (int i = 0; i < 22; i++) begin
         tick();
         check($sformatf("b2b_c%0d_tx", i), tx, exp37[i]);
         check($sformatf("b2b_c%0d_done", i), tx_done, (i == 10) || (i == 21));
         check($sformatf("b2b_c%0d_busy", i), busy, 1);
      end
      tick();
      check("b2b_end_tx", tx, 1);
      check("b2b_end_busy", busy, 0);
      check("b2b_ovf_sticky", ovf, 1);

      // Reset during data bit 3 aborts the frame and flushes the queued byte
      tx_en = 1'b0; lcr = 8'h00; div = 16'd4;
      write_byte(8'h00);
      write_byte(8'h77);
      tx_en = 1'b1;
      tick();
      for (int i = 0; i < 18; i++) tick();
      check("rstmid_tx_low", tx, 0);
      check("rstmid_busy", busy, 1);
      check("rstmid_level", level, 1);
      rst = 1'b1;
      tick();
      check("rstmid_after_tx", tx, 1);
      check("rstmid_after_level", level, 0);
      check("rstmid_after_busy", busy, 0);
      check("rstmid_after_done", tx_done, 0);
      check("rstmid_after_empty", empty, 1);
      check("rstmid_after_ovf", ovf, 0);
      rst = 1'b0;
      lows = 0; dones = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (tx !== 1'b1) lows++;
         if (tx_done !== 1'b0) dones++;
      end
      check("rstmid_no_tx", lows, 0);
      check("rstmid_no_done", dones, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
